// File: rtl/twos_neg_pipe_pkg.sv
// Shared definitions for the pipelined two's-complement negate/abs unit:
// mode encodings and pipeline-geometry helpers.
package twos_neg_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_ONES = 2'b11
    } mode_e;

    // Number of carry-chain segments, one register stage each.
    function automatic int calc_nstg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // The top segment carries whatever bits remain after the full-width ones.
    function automatic int last_seg_w(input int width, input int seg);
        return width - (calc_nstg(width, seg) - 1) * seg;
    endfunction

endpackage

// File: rtl/twos_neg_seg.sv
// One slice of the segmented +1 carry chain: adds a single carry-in bit
// to a W-bit word and reports the carry-out to the next stage.
module twos_neg_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, data_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/twos_neg_pipe.sv
// Pipelined negate / abs / ones'-complement unit with a valid/ready stream
// interface; the +1 carry ripples through one SEG-bit segment per stage.
module twos_neg_pipe
    import twos_neg_pipe_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTG  = calc_nstg(WIDTH, SEG);
    localparam int LASTW = last_seg_w(WIDTH, SEG);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mode_e            mode_in;
    logic             inv;
    logic             add1;
    logic             ovf_in;
    logic [WIDTH-1:0] word_in;

    assign mode_in = mode_e'(mode);
    assign inv     = (mode_in == MODE_NEG) | (mode_in == MODE_ONES) |
                     ((mode_in == MODE_ABS) & in[WIDTH-1]);
    assign add1    = inv & (mode_in != MODE_ONES);
    assign word_in = inv ? ~in : in;
    assign ovf_in  = add1 & (in == MOST_NEG);

    logic [NSTG-1:0]  v;
    logic [NSTG-1:0]  adv;
    logic [NSTG-1:0]  ld;
    logic [NSTG-1:0]  cy;
    logic [NSTG-1:0]  ov;
    logic [WIDTH-1:0] dat [NSTG];

    // A stage moves on when it is full and the stage ahead is empty or
    // itself moving on; this collapses bubbles without a skid buffer.
    always_comb begin
        adv = '0;
        adv[NSTG-1] = v[NSTG-1] & out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign ld       = ~v | adv;
    assign in_ready = ld[0];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LSB = k * SEG;
        localparam int SW  = (k == NSTG - 1) ? LASTW : SEG;

        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic [SW-1:0]    sum;
        logic             cin;
        logic             cout;
        logic             ovf_src;
        logic             v_src;
        logic             v_q;
        logic             c_q;
        logic             ovf_q;

        if (k == 0) begin : g_head
            assign src     = word_in;
            assign cin     = add1;
            assign ovf_src = ovf_in;
            assign v_src   = in_valid;
        end else begin : g_body
            assign src     = dat[k-1];
            assign cin     = cy[k-1];
            assign ovf_src = ov[k-1];
            assign v_src   = adv[k-1];
        end

        twos_neg_seg #(.W(SW)) u_seg (
            .data_i (src[LSB +: SW]),
            .cin_i  (cin),
            .sum_o  (sum),
            .cout_o (cout)
        );

        always_comb begin
            data_d = src;
            data_d[LSB +: SW] = sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                data_q <= '0;
                c_q    <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (ld[k]) begin
                v_q <= v_src;
                if (v_src) begin
                    data_q <= data_d;
                    c_q    <= cout;
                    ovf_q  <= ovf_src;
                end
            end
        end

        assign v[k]   = v_q;
        assign dat[k] = data_q;
        assign cy[k]  = c_q;
        assign ov[k]  = ovf_q;
    end

    // Result is modulo 2^WIDTH, so the top carry has no consumer.
    logic unused_final_carry;
    assign unused_final_carry = cy[NSTG-1];

    assign out       = dat[NSTG-1];
    assign out_valid = v[NSTG-1];
    assign ovf       = ov[NSTG-1];
    assign zero      = v[NSTG-1] & ~|dat[NSTG-1];

endmodule

// File: tb/tb_twos_neg_pipe.sv
// Bench for twos_neg_pipe: directed and random items on a 24-bit/3-stage and
// a 25-bit/4-stage instance, checked against an arithmetic reference model.
module tb_twos_neg_pipe;
    import twos_neg_pipe_pkg::*;

    typedef struct packed {
        logic        z;
        logic        o;
        logic [31:0] r;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] a_in;
    logic [1:0]  a_mode;
    logic        a_iv, a_ir, a_ov, a_ordy, a_ovf, a_zero;
    logic [23:0] a_out;
    logic [24:0] b_in;
    logic [1:0]  b_mode;
    logic        b_iv, b_ir, b_ov, b_ordy, b_ovf, b_zero;
    logic [24:0] b_out;

    int vectors = 0;
    int miscompares = 0;

    twos_neg_pipe #(.WIDTH(24), .SEG(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .mode(a_mode), .in_valid(a_iv),
        .in_ready(a_ir), .out(a_out), .out_valid(a_ov), .out_ready(a_ordy),
        .ovf(a_ovf), .zero(a_zero)
    );

    twos_neg_pipe #(.WIDTH(25), .SEG(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .mode(b_mode), .in_valid(b_iv),
        .in_ready(b_ir), .out(b_out), .out_valid(b_ov), .out_ready(b_ordy),
        .ovf(b_ovf), .zero(b_zero)
    );

    function automatic exp_t model(input int w, input logic [1:0] md, input logic [31:0] x);
        longint unsigned mask, minv, xv, r;
        bit neg, o;
        exp_t e;
        mask = (64'd1 << w) - 1;
        minv = 64'd1 << (w - 1);
        xv   = {32'd0, x} & mask;
        neg  = xv >= minv;
        case (md)
            2'b00:   r = xv;
            2'b01:   r = -xv;
            2'b10:   r = neg ? -xv : xv;
            default: r = ~xv;
        endcase
        r = r & mask;
        o = ((md == 2'b01) || (md == 2'b10 && neg)) && (xv == minv);
        e.r = r[31:0];
        e.o = o;
        e.z = (r == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input bit wide, input logic [1:0] md, input logic [31:0] x,
                           input int exp_lat, input string tag);
        exp_t e;
        int   lat;
        e = model(wide ? 25 : 24, md, x);
        @(negedge clk);
        if (wide) begin
            b_in = x[24:0]; b_mode = md; b_iv = 1'b1; b_ordy = 1'b1;
        end else begin
            a_in = x[23:0]; a_mode = md; a_iv = 1'b1; a_ordy = 1'b1;
        end
        #1;
        chk({tag, ".in_ready"}, {31'd0, wide ? b_ir : a_ir}, 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        a_iv = 1'b0;
        b_iv = 1'b0;
        while (!(wide ? b_ov : a_ov) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".out_valid"}, {31'd0, wide ? b_ov : a_ov}, 32'd1);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".out"}, wide ? 32'(b_out) : 32'(a_out), e.r);
        chk({tag, ".ovf"}, {31'd0, wide ? b_ovf : a_ovf}, {31'd0, e.o});
        chk({tag, ".zero"}, {31'd0, wide ? b_zero : a_zero}, {31'd0, e.z});
    endtask

    initial begin
        exp_t        q[$];
        exp_t        e;
        int          left, cyc;
        bit          held;
        logic [23:0] hv;
        logic        hovf, hz;
        logic [31:0] x;

        rst_n = 1'b0;
        a_in = '0; a_mode = '0; a_iv = 1'b0; a_ordy = 1'b1;
        b_in = '0; b_mode = '0; b_iv = 1'b0; b_ordy = 1'b1;
        #1;
        chk("reset.out", 32'(a_out), 32'd0);
        chk("reset.out_valid", {31'd0, a_ov}, 32'd0);
        chk("reset.ovf", {31'd0, a_ovf}, 32'd0);
        chk("reset.zero", {31'd0, a_zero}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", {31'd0, a_ir}, 32'd1);

        // Directed cases from the test plan.
        run_one(1'b0, MODE_NEG,  32'h000001, 3, "neg1");
        run_one(1'b0, MODE_ABS,  32'h800000, 3, "abs_min");
        run_one(1'b0, MODE_ABS,  32'hFFFFFE, 3, "abs_m2");
        run_one(1'b0, MODE_ONES, 32'h00FF00, 3, "ones");
        run_one(1'b0, MODE_NEG,  32'h000000, 3, "neg0");
        run_one(1'b0, MODE_PASS, 32'h800000, 3, "pass_min");
        run_one(1'b0, MODE_NEG,  32'h800000, 3, "neg_min");
        run_one(1'b1, MODE_NEG,  32'h0000100, 4, "w25_neg");
        run_one(1'b1, MODE_NEG,  32'h1000000, 4, "w25_neg_min");
        run_one(1'b1, MODE_ABS,  32'h1FFFFFF, 4, "w25_abs_m1");

        for (int i = 0; i < 6; i++) begin
            run_one(1'b0, 2'($urandom_range(0, 3)), $urandom, 3, "rnd24");
            run_one(1'b1, 2'($urandom_range(0, 3)), $urandom, 4, "rnd25");
        end

        // Random stream with back-pressure on the 24-bit instance.
        left = 40;
        cyc  = 0;
        held = 1'b0;
        hv = '0; hovf = 1'b0; hz = 1'b0;
        while ((left > 0 || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk("stall.valid", {31'd0, a_ov}, 32'd1);
                chk("stall.out", 32'(a_out), 32'(hv));
                chk("stall.ovf", {31'd0, a_ovf}, {31'd0, hovf});
                chk("stall.zero", {31'd0, a_zero}, {31'd0, hz});
            end
            if (a_ov) chk("stream.no_spurious", {31'd0, q.size() > 0}, 32'd1);
            a_ordy = 1'($urandom_range(0, 1));
            a_iv   = (left > 0) && ($urandom_range(0, 3) != 0);
            x = $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h800000;
            if ($urandom_range(0, 7) == 0) x = 32'h000000;
            a_in   = x[23:0];
            a_mode = 2'($urandom_range(0, 3));
            #1;
            chk("stream.in_ready", {31'd0, a_ir},
                (q.size() == 3 && !a_ordy) ? 32'd0 : 32'd1);
            if (a_ov && a_ordy && q.size() > 0) begin
                e = q.pop_front();
                chk("stream.out", 32'(a_out), e.r);
                chk("stream.ovf", {31'd0, a_ovf}, {31'd0, e.o});
                chk("stream.zero", {31'd0, a_zero}, {31'd0, e.z});
            end
            held = a_ov && !a_ordy;
            hv = a_out; hovf = a_ovf; hz = a_zero;
            if (a_iv && a_ir) begin
                q.push_back(model(24, a_mode, {8'd0, a_in}));
                left--;
            end
        end
        chk("stream.items_left", left, 0);
        chk("stream.drained", q.size(), 0);

        // Reset with three items in flight.
        @(negedge clk);
        a_ordy = 1'b0; a_iv = 1'b1; a_mode = MODE_NEG; a_in = 24'h000005;
        @(negedge clk);
        a_in = 24'h000007;
        @(negedge clk);
        a_in = 24'h000009;
        @(negedge clk);
        a_iv = 1'b0;
        chk("flight.out_valid", {31'd0, a_ov}, 32'd1);
        chk("flight.out", 32'(a_out), 32'hFFFFFB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out", 32'(a_out), 32'd0);
        chk("async_rst.out_valid", {31'd0, a_ov}, 32'd0);
        chk("async_rst.ovf", {31'd0, a_ovf}, 32'd0);
        chk("async_rst.zero", {31'd0, a_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_ordy = 1'b1;
        #1;
        chk("post_rst.in_ready", {31'd0, a_ir}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst.no_stale", {31'd0, a_ov}, 32'd0);
        end
        run_one(1'b0, MODE_NEG, 32'h000003, 3, "post_rst");
        @(negedge clk);
        chk("post_rst.single", {31'd0, a_ov}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
